vga_timing_generator: RTL
=========================

// Module: vga_timing_generator
// PURPOSE
//  Parametrised raster timing generator for the VGA output path: produces H/V sync, display-enable,
//  pixel coordinates and line/frame strobes for any VESA-style mode. Adds a pixel clock-enable,
//  per-axis sync polarity and an output delay pipeline so sync/DE/coordinates arrive aligned with
//  pixel data from a multi-cycle renderer. Sits between the pixel-clock PLL and the frame renderer.
// PARAMETERS
//  CNTR_WIDTH_H   11   horizontal counter width; 2**CNTR_WIDTH_H >= WHOLE_H required
//  CNTR_WIDTH_V   10   vertical counter width; 2**CNTR_WIDTH_V >= WHOLE_V required
//  VISIBLE_H      800  active pixels per line
//  FRONT_PORCH_H  40   pixels
//  SYNC_PULSE_H   128  pixels
//  BACK_PORCH_H   88   pixels
//  VISIBLE_V      600  active lines per frame
//  FRONT_PORCH_V  1    lines
//  SYNC_PULSE_V   4    lines
//  BACK_PORCH_V   23   lines
//  HS_POL         1    1 = HS active-high, 0 = active-low
//  VS_POL         1    1 = VS active-high, 0 = active-low
//  PIPE_DLY       1    output pipeline depth in PIX_EN ticks (1..8)
// PORTS
//  VGA_CLK        in   1             pixel-domain clock
//  RST_N          in   1             asynchronous active-low reset
//  PIX_EN         in   1             pixel tick; all state advances only when 1
//  VGA_HS         out  1             horizontal sync, polarity HS_POL
//  VGA_VS         out  1             vertical sync, polarity VS_POL
//  inDisplayArea  out  1             display enable
//  CounterX       out  CNTR_WIDTH_H  pixel column, aligned with outputs
//  CounterY       out  CNTR_WIDTH_V  pixel line, aligned with outputs
//  LineStart      out  1             1-cycle strobe, outputs advanced to X==0
//  FrameStart     out  1             1-cycle strobe, outputs advanced to X==0,Y==0
//  VBlank         out  1             high while output Y >= VISIBLE_V
// BEHAVIOUR
//  - One clock VGA_CLK; reset is asynchronous, active-low (RST_N). WHOLE_H/WHOLE_V = sum of axis params.
//  - Reset (async assert, sync release): internal h/v = 0; all pipeline stages cleared; VGA_HS=~HS_POL,
//    VGA_VS=~VS_POL, inDisplayArea=0, CounterX=0, CounterY=0, LineStart=0, FrameStart=0, VBlank=0.
//  - Counting on PIX_EN=1: h==WHOLE_H-1 -> h=0, v+1; v==WHOLE_V-1 at h wrap -> v=0. Else h+1.
//    Ranges are h 0..WHOLE_H-1, v 0..WHOLE_V-1; terminal values never appear as 0-length extras.
//  - Sync active (inclusive): h in [VISIBLE_H+FRONT_PORCH_H, VISIBLE_H+FRONT_PORCH_H+SYNC_PULSE_H-1];
//    v in [VISIBLE_V+FRONT_PORCH_V, VISIBLE_V+FRONT_PORCH_V+SYNC_PULSE_V-1]. Exactly SYNC_PULSE_* long.
//  - DE = (h < VISIBLE_H) && (v < VISIBLE_V). VBlank = v >= VISIBLE_V.
//  - Pipeline: {h,v,HS,VS,DE,VBlank} pass through PIPE_DLY registered stages, each shifting only on
//    PIX_EN=1. All outputs registered, mutually aligned; counter->output latency = PIPE_DLY ticks.
//  - PIX_EN=0: every output holds; strobes forced 0. Strobes high for exactly one VGA_CLK cycle,
//    the cycle after the shift that brings X==0 (and Y==0) to the outputs.
//  - Reset mid-frame: immediate return to reset values; after release first tick begins at (0,0).
//  - First frame after reset: FrameStart fires when (0,0) first reaches outputs (after PIPE_DLY ticks).
// CONFIGURATION
//  HVSYNC_FRAME_CNT_EN defined: extra port FrameCount out 16 bits; reset 0; +1 in the cycle FrameStart
//    is high; 16'hFFFF wraps to 0. Undefined: port and logic absent; all other behaviour identical.
// TESTING  (default params: WHOLE_H=1056, WHOLE_V=628, PIX_EN=1 unless stated)
//  1 Reset then run -> VGA_HS high for exactly 128 cycles at CounterX 840..967; HS period 1056 cycles.
//  2 Run 2 frames -> VGA_VS high for 4224 cycles (CounterY 601..604); FrameStart every 663168 cycles;
//    LineStart every 1056 cycles.
//  3 Check DE -> inDisplayArea high 800 cycles/line on Y 0..599, low on Y 600..627; first DE cycle has
//    X=0; VBlank high exactly on Y 600..627; repeat with PIPE_DLY=3 -> same alignment, +3 latency.
//  4 PIX_EN toggling 1,0,1,0 -> all periods double; outputs stable on PIX_EN=0; strobes 1 cycle wide.
//  5 Assert RST_N low at X=500,Y=300 with no clock edge -> outputs at reset values immediately;
//    release -> restart at (0,0). HS_POL=0/VS_POL=0 -> syncs inverted, idle level 1 in reset.
//  6 HVSYNC_FRAME_CNT_EN, tiny mode (VISIBLE 4x2, porches/sync 1) -> FrameCount=3 after 3 frames;
//    preload near wrap by forcing 65535 frames' worth -> 16'hFFFF then 0.

Source files
------------

// File: rtl/vga_timing_generator.sv
// Raster timing generator: H/V counters, sync/DE/VBlank decode and a PIX_EN-gated output pipeline.
// Optional HVSYNC_FRAME_CNT_EN adds a 16-bit FrameCount output.
module vga_timing_generator #(
    parameter int unsigned CNTR_WIDTH_H  = 11,
    parameter int unsigned CNTR_WIDTH_V  = 10,
    parameter int unsigned VISIBLE_H     = 800,
    parameter int unsigned FRONT_PORCH_H = 40,
    parameter int unsigned SYNC_PULSE_H  = 128,
    parameter int unsigned BACK_PORCH_H  = 88,
    parameter int unsigned VISIBLE_V     = 600,
    parameter int unsigned FRONT_PORCH_V = 1,
    parameter int unsigned SYNC_PULSE_V  = 4,
    parameter int unsigned BACK_PORCH_V  = 23,
    parameter bit          HS_POL        = 1'b1,
    parameter bit          VS_POL        = 1'b1,
    parameter int unsigned PIPE_DLY      = 1
) (
    input  logic                    VGA_CLK,
    input  logic                    RST_N,
    input  logic                    PIX_EN,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    inDisplayArea,
    output logic [CNTR_WIDTH_H-1:0] CounterX,
    output logic [CNTR_WIDTH_V-1:0] CounterY,
    output logic                    LineStart,
    output logic                    FrameStart,
    output logic                    VBlank
`ifdef HVSYNC_FRAME_CNT_EN
    ,
    output logic [15:0]             FrameCount
`endif
);

    localparam int unsigned WHOLE_H = VISIBLE_H + FRONT_PORCH_H + SYNC_PULSE_H + BACK_PORCH_H;
    localparam int unsigned WHOLE_V = VISIBLE_V + FRONT_PORCH_V + SYNC_PULSE_V + BACK_PORCH_V;
    localparam int unsigned FILL_W  = 4;

    localparam logic [CNTR_WIDTH_H-1:0] H_LAST   = CNTR_WIDTH_H'(WHOLE_H - 1);
    localparam logic [CNTR_WIDTH_H-1:0] H_VIS    = CNTR_WIDTH_H'(VISIBLE_H);
    localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_S = CNTR_WIDTH_H'(VISIBLE_H + FRONT_PORCH_H);
    localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_E = CNTR_WIDTH_H'(VISIBLE_H + FRONT_PORCH_H + SYNC_PULSE_H - 1);
    localparam logic [CNTR_WIDTH_V-1:0] V_LAST   = CNTR_WIDTH_V'(WHOLE_V - 1);
    localparam logic [CNTR_WIDTH_V-1:0] V_VIS    = CNTR_WIDTH_V'(VISIBLE_V);
    localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_S = CNTR_WIDTH_V'(VISIBLE_V + FRONT_PORCH_V);
    localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_E = CNTR_WIDTH_V'(VISIBLE_V + FRONT_PORCH_V + SYNC_PULSE_V - 1);
    localparam logic [FILL_W-1:0]       FILL_END = FILL_W'(PIPE_DLY - 1);

    typedef struct packed {
        logic [CNTR_WIDTH_H-1:0] x;
        logic [CNTR_WIDTH_V-1:0] y;
        logic                    hs;
        logic                    vs;
        logic                    de;
        logic                    vb;
    } stage_t;

    localparam stage_t STAGE_RST = '{x: '0, y: '0, hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, vb: 1'b0};

    logic [CNTR_WIDTH_H-1:0] h_q, h_d;
    logic [CNTR_WIDTH_V-1:0] v_q, v_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic                    fill_done_c;
    logic                    line_start_q, line_start_d;
    logic                    frame_start_q, frame_start_d;
    stage_t                  head_c;
    stage_t                  tail_in_c;
    stage_t                  pipe_q [PIPE_DLY];

    // Raster counters
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (PIX_EN) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNTR_WIDTH_V'(1);
            end else begin
                h_d = h_q + CNTR_WIDTH_H'(1);
            end
        end
    end

    // Decode of the current counter position into the pipeline head
    always_comb begin
        head_c    = STAGE_RST;
        head_c.x  = h_q;
        head_c.y  = v_q;
        head_c.hs = ((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E)) ? HS_POL : ~HS_POL;
        head_c.vs = ((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E)) ? VS_POL : ~VS_POL;
        head_c.de = (h_q < H_VIS) && (v_q < V_VIS);
        head_c.vb = (v_q >= V_VIS);
    end

    // Value about to be shifted into the output stage
    if (PIPE_DLY == 1) begin : g_tail_head
        assign tail_in_c = head_c;
    end else begin : g_tail_pipe
        assign tail_in_c = pipe_q[PIPE_DLY-2];
    end

    // fill_q suppresses strobes while cleared stages drain out after reset
    always_comb begin
        fill_done_c   = (fill_q == FILL_END);
        fill_d        = (PIX_EN && !fill_done_c) ? fill_q + FILL_W'(1) : fill_q;
        line_start_d  = PIX_EN && fill_done_c && (tail_in_c.x == '0);
        frame_start_d = line_start_d && (tail_in_c.y == '0);
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q           <= '0;
            v_q           <= '0;
            fill_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            for (int unsigned i = 0; i < PIPE_DLY; i++) begin
                pipe_q[i] <= STAGE_RST;
            end
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            fill_q        <= fill_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (PIX_EN) begin
                pipe_q[0] <= head_c;
                for (int unsigned i = 1; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign VGA_HS        = pipe_q[PIPE_DLY-1].hs;
    assign VGA_VS        = pipe_q[PIPE_DLY-1].vs;
    assign inDisplayArea = pipe_q[PIPE_DLY-1].de;
    assign CounterX      = pipe_q[PIPE_DLY-1].x;
    assign CounterY      = pipe_q[PIPE_DLY-1].y;
    assign VBlank        = pipe_q[PIPE_DLY-1].vb;
    assign LineStart     = line_start_q;
    assign FrameStart    = frame_start_q;

`ifdef HVSYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts frames as FrameStart is seen; wraps naturally at 16'hFFFF
    always_comb begin
        frame_cnt_d = frame_start_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign FrameCount = frame_cnt_q;
`endif

endmodule
